debug_halt_ctrl: RTL and testbench

Parametrised run/step/breakpoint controller that decides, each cycle, whether the CPU core is halted. It is the successor to the single-breakpoint fixed-mode halt logic beside the clock generator. It adds a debounced step button, four run modes including counted instruction stepping, and NUM_BP maskable breakpoint channels with a sticky cause report. It sits between the front-panel switches/buttons and the core's halt input.

---
 rtl/debug_halt_ctrl_pkg.sv | 18 +
 rtl/debug_halt_ctrl_btn_debounce.sv | 49 ++++
 rtl/debug_halt_ctrl.sv | 160 ++++++++++++++++
 tb/tb_debug_halt_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_halt_ctrl_pkg.sv
// Shared encodings for the debug halt controller: panel mode switches and FSM states.
// The FSM state values double as the o_state LED codes.
package debug_halt_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_CYCLE = 2'b01,
      MODE_INSTR = 2'b10,
      MODE_COUNT = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

endpackage

// File: rtl/debug_halt_ctrl_btn_debounce.sv
// Synchronise and debounce one panel button; emits the stable level and a
// one-cycle registered pulse on its rising edge.
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_risePulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_levelD;
   logic                   r_rise;
   logic                   w_btn;

   assign w_btn       = r_sync[SYNC_STAGES-1];
   assign o_level     = r_level;
   assign o_risePulse = r_rise;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_level  <= 1'b0;
         r_levelD <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
         // any cycle matching the current level restarts the stability count
         if (w_btn == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= w_btn;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_levelD <= r_level;
         r_rise   <= r_level & ~r_levelD;
      end
   end

endmodule

// File: rtl/debug_halt_ctrl.sv
// Run/step/breakpoint halt controller between the front panel and the core's
// halt input. o_halt and o_state are registered from the next FSM state.
module debug_halt_ctrl
   import debug_halt_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int NUM_BP          = 4,
   parameter int STEP_CNT_W      = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_btnStep,
   input  logic [1:0]            i_mode,
   input  logic [STEP_CNT_W-1:0] i_stepCount,
   input  logic [NUM_BP-1:0]     i_bpEnable,
   input  logic [NUM_BP-1:0]     i_bpHit,
   input  logic                  i_instrFinished,
   output logic                  o_halt,
   output logic                  o_bpHalted,
   output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] o_bpIdx,
   output logic [1:0]            o_state
);
   localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

   function automatic logic [IDX_W-1:0] f_lowestSet(input logic [NUM_BP-1:0] v);
      f_lowestSet = '0;
      for (int i = NUM_BP - 1; i >= 0; i--)
         if (v[i]) f_lowestSet = IDX_W'(i);
   endfunction

   logic [SYNC_STAGES-1:0][1:0]        r_syncMode;
   logic [SYNC_STAGES-1:0][NUM_BP-1:0] r_syncEn;
   logic [SYNC_STAGES-1:0]             r_syncVld;
   state_e                  r_state;
   mode_e                   r_stepMode;
   logic [STEP_CNT_W-1:0]   r_remaining;
   logic                    r_halt;
   logic                    r_bpHalted;
   logic [IDX_W-1:0]        r_bpIdx;

   logic                    w_btnLevel;
   logic                    w_btnRise;
   logic                    w_stepPulse;
   mode_e                   w_mode;
   logic [NUM_BP-1:0]       w_bpMask;
   logic                    w_bpTrig;
   logic                    w_syncVld;

   btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btnStep (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_btn      (i_btnStep),
      .o_level    (w_btnLevel),
      .o_risePulse(w_btnRise)
   );

   // the level qualifier only matters at DEBOUNCE_CYCLES=1, where a level can drop right after rising
   assign w_stepPulse = w_btnRise & w_btnLevel;
   assign w_mode      = mode_e'(r_syncMode[SYNC_STAGES-1]);
   assign w_bpMask    = i_bpHit & r_syncEn[SYNC_STAGES-1];
   assign w_bpTrig    = |w_bpMask;
   assign w_syncVld   = r_syncVld[SYNC_STAGES-1];

   assign o_halt     = r_halt;
   assign o_bpHalted = r_bpHalted;
   assign o_bpIdx    = r_bpIdx;
   assign o_state    = r_state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_syncMode <= '0;
         r_syncEn   <= '0;
         r_syncVld  <= '0;
      end else begin
         r_syncMode <= {r_syncMode[SYNC_STAGES-2:0], i_mode};
         r_syncEn   <= {r_syncEn[SYNC_STAGES-2:0], i_bpEnable};
         r_syncVld  <= {r_syncVld[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // HALT ignores the switches until the synchronisers hold post-reset samples,
   // so the all-zero reset value (which reads as RUN) cannot start the core.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_HALT;
         r_halt      <= 1'b1;
         r_bpHalted  <= 1'b0;
         r_bpIdx     <= '0;
         r_remaining <= '0;
         r_stepMode  <= MODE_RUN;
      end else begin
         case (r_state)
            ST_HALT: begin
               if (w_syncVld) begin
                  if (w_stepPulse) begin
                     r_bpHalted <= 1'b0;
                     r_stepMode <= w_mode;
                     r_halt     <= 1'b0;
                     case (w_mode)
                        MODE_RUN:   r_state <= ST_RUN;
                        MODE_CYCLE: begin
                           r_state     <= ST_STEP;
                           r_remaining <= '0;
                        end
                        MODE_INSTR: begin
                           r_state     <= ST_STEP;
                           r_remaining <= STEP_CNT_W'(1);
                        end
                        default: begin
                           r_state     <= ST_STEP;
                           r_remaining <= (i_stepCount == '0) ? STEP_CNT_W'(1) : i_stepCount;
                        end
                     endcase
                  end else if (w_mode == MODE_RUN && !r_bpHalted) begin
                     r_state <= ST_RUN;
                     r_halt  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (w_bpTrig) begin
                  r_state    <= ST_HALT;
                  r_halt     <= 1'b1;
                  r_bpHalted <= 1'b1;
                  r_bpIdx    <= f_lowestSet(w_bpMask);
               end else if (w_mode != MODE_RUN) begin
                  r_state <= ST_HALT;
                  r_halt  <= 1'b1;
               end
            end
            ST_STEP: begin
               if (w_bpTrig) begin
                  r_state    <= ST_HALT;
                  r_halt     <= 1'b1;
                  r_bpHalted <= 1'b1;
                  r_bpIdx    <= f_lowestSet(w_bpMask);
               end else if (w_mode != r_stepMode || r_stepMode == MODE_CYCLE) begin
                  r_state <= ST_HALT;
                  r_halt  <= 1'b1;
               end else if (i_instrFinished) begin
                  if (r_remaining == STEP_CNT_W'(1)) begin
                     r_state <= ST_HALT;
                     r_halt  <= 1'b1;
                  end
                  if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
               end
            end
            default: begin
               r_state <= ST_HALT;
               r_halt  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Bench for debug_halt_ctrl: directed timing checks from the datasheet numbers,
// then randomized panel/datapath activity against a behavioural model.
module tb_debug_halt_ctrl;
   localparam int S  = 2;
   localparam int D  = 16;
   localparam int NB = 4;
   localparam int W  = 8;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_btnStep = 1'b0;
   logic [1:0]    i_mode = 2'b00;
   logic [W-1:0]  i_stepCount = '0;
   logic [NB-1:0] i_bpEnable = '0;
   logic [NB-1:0] i_bpHit = '0;
   logic          i_instrFinished = 1'b0;
   logic          o_halt;
   logic          o_bpHalted;
   logic [1:0]    o_bpIdx;
   logic [1:0]    o_state;

   debug_halt_ctrl #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .NUM_BP(NB), .STEP_CNT_W(W)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_btnStep(i_btnStep), .i_mode(i_mode),
      .i_stepCount(i_stepCount), .i_bpEnable(i_bpEnable), .i_bpHit(i_bpHit),
      .i_instrFinished(i_instrFinished), .o_halt(o_halt), .o_bpHalted(o_bpHalted),
      .o_bpIdx(o_bpIdx), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: switches modelled as fixed-latency delay lines, button as a
   // run-length filter, controller as "what is the core doing" (0 halt,1 run,2 step)
   int mq[$], eq[$], bq[$];
   int m_since, m_lvl, m_run, m_prev, m_rise;
   int m_st, m_bph, m_idx, m_rem, m_smode;

   function automatic void model_reset();
      mq.delete(); eq.delete(); bq.delete();
      for (int i = 0; i < S; i++) begin
         mq.push_back(0); eq.push_back(0); bq.push_back(0);
      end
      m_since = 0; m_lvl = 0; m_run = 0; m_prev = 0; m_rise = 0;
      m_st = 0; m_bph = 0; m_idx = 0; m_rem = 0; m_smode = 0;
   endfunction

   function automatic void model_step();
      int mode, hits, idx, nrise;
      mode = mq[0];
      hits = int'(i_bpHit) & eq[0];
      idx = 0;
      if (hits != 0) while (((hits >> idx) & 1) == 0) idx++;
      if (m_st != 0 && hits != 0) begin
         m_st = 0; m_bph = 1; m_idx = idx;
      end else if (m_st == 1) begin
         if (mode != 0) m_st = 0;
      end else if (m_st == 2) begin
         if (mode != m_smode || m_smode == 1) m_st = 0;
         else if (i_instrFinished) begin
            if (m_rem == 1) m_st = 0;
            if (m_rem > 0) m_rem = m_rem - 1;
         end
      end else if (m_since >= S) begin
         if (m_rise != 0) begin
            m_bph = 0; m_smode = mode;
            m_st  = (mode == 0) ? 1 : 2;
            if (mode == 2) m_rem = 1;
            else if (mode == 3) m_rem = (i_stepCount == 0) ? 1 : int'(i_stepCount);
            else m_rem = 0;
         end else if (mode == 0 && m_bph == 0) m_st = 1;
      end
      nrise  = (m_lvl == 1 && m_prev == 0) ? 1 : 0;
      m_prev = m_lvl;
      if (bq[0] != m_lvl) begin
         m_run++;
         if (m_run == D) begin m_lvl = bq[0]; m_run = 0; end
      end else m_run = 0;
      m_rise = nrise;
      mq.push_back(int'(i_mode));     void'(mq.pop_front());
      eq.push_back(int'(i_bpEnable)); void'(eq.pop_front());
      bq.push_back(int'(i_btnStep));  void'(bq.pop_front());
      if (m_since < S) m_since++;
   endfunction

   task automatic tick();
      model_step();
      @(posedge i_clk);
      #1;
      chk("halt", o_halt, (m_st == 0) ? 1 : 0);
      chk("state", o_state, m_st);
      chk("bpHalted", o_bpHalted, m_bph);
      chk("bpIdx", o_bpIdx, m_idx);
   endtask

   // assert reset between edges; outputs must fall back without a clock
   task automatic do_reset();
      i_reset = 1'b1;
      #1;
      model_reset();
      chk("rst_halt", o_halt, 1);
      chk("rst_state", o_state, 0);
      chk("rst_bpHalted", o_bpHalted, 0);
      chk("rst_bpIdx", o_bpIdx, 0);
      #3;
      i_reset = 1'b0;
   endtask

   task automatic press_until_moving(input string tag);
      int k;
      k = 0;
      i_btnStep = 1'b1;
      while (o_halt && k < 100) begin tick(); k++; end
      chk(tag, o_halt, 0);
      i_btnStep = 1'b0;
   endtask

   initial begin
      int lows, low_at, hold;
      model_reset();
      @(posedge i_clk);
      #1;
      do_reset();

      // reset release with mode RUN: starts running SYNC_STAGES+1 cycles later
      for (int k = 1; k <= S + 1; k++) begin
         tick();
         chk("release_halt", o_halt, (k <= S) ? 1 : 0);
      end
      chk("release_state", o_state, 1);

      // breakpoint on channel 1 (en 0110, hit 1110), then resume by step press
      i_bpEnable = 4'b0110;
      repeat (S + 1) tick();
      i_bpHit = 4'b1110;
      tick();
      i_bpHit = '0;
      chk("bp_halt", o_halt, 1);
      chk("bp_flag", o_bpHalted, 1);
      chk("bp_idx", o_bpIdx, 1);
      repeat (5) tick();
      chk("bp_sticky", o_halt, 1);
      i_btnStep = 1'b1;
      for (int k = 1; k <= S + D + 2; k++) begin
         tick();
         if (k == S + D + 1) chk("resume_not_yet", o_halt, 1);
      end
      chk("resume_halt", o_halt, 0);
      chk("resume_flag", o_bpHalted, 0);
      i_btnStep = 1'b0;
      repeat (S + D + 4) tick();

      // CYCLE step from a clean 40-cycle press
      i_bpEnable = '0;
      i_mode = 2'b01;
      repeat (S + 3) tick();
      chk("cycle_idle", o_halt, 1);
      lows = 0; low_at = -1;
      i_btnStep = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (!o_halt) begin lows++; low_at = k; end
      end
      chk("cycle_lows", lows, 1);
      chk("cycle_when", low_at, S + D + 2);
      i_btnStep = 1'b0;
      repeat (S + D + 4) tick();

      // bouncing press: toggles every 5 cycles for 60 cycles, then steady
      lows = 0;
      for (int k = 0; k < 60; k++) begin
         i_btnStep = ((k / 5) % 2 == 0);
         tick();
         if (!o_halt) lows++;
      end
      i_btnStep = 1'b1;
      repeat (40) begin
         tick();
         if (!o_halt) lows++;
      end
      chk("bounce_lows", lows, 1);
      i_btnStep = 1'b0;
      repeat (S + D + 4) tick();

      // COUNT step of 3 instructions, then count 0 acts as 1
      i_mode = 2'b11;
      i_stepCount = 8'd3;
      repeat (S + 2) tick();
      press_until_moving("count3_start");
      for (int p = 1; p <= 3; p++) begin
         repeat (2) tick();
         i_instrFinished = 1'b1;
         tick();
         i_instrFinished = 1'b0;
         chk("count3_after_pulse", o_halt, (p == 3) ? 1 : 0);
      end
      repeat (S + D + 4) tick();
      i_stepCount = 8'd0;
      press_until_moving("count0_start");
      repeat (3) tick();
      i_instrFinished = 1'b1;
      tick();
      i_instrFinished = 1'b0;
      chk("count0_after_pulse", o_halt, 1);
      repeat (S + D + 4) tick();

      // INSTR step interrupted by reset
      i_mode = 2'b10;
      repeat (S + 2) tick();
      press_until_moving("instr_start");
      chk("instr_state", o_state, 2);
      repeat (3) tick();
      do_reset();
      repeat (S + D + 4) tick();

      // randomized activity against the model
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            i_btnStep = ~i_btnStep;
            hold = $urandom_range(1, 45);
         end else hold--;
         if ($urandom_range(0, 99) == 0) i_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) i_bpEnable = NB'($urandom);
         i_bpHit = ($urandom_range(0, 15) == 0) ? NB'($urandom) : '0;
         i_instrFinished = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) i_stepCount = W'($urandom_range(0, 4));
         if ($urandom_range(0, 999) == 0) do_reset();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
